// File: rtl/acc_dcache_port_arbiter.sv
// ----------------------------------------------------------------------------
// acc_dcache_port_arbiter
//
// Shares one write-through D-cache request port between the CVA6 load/store
// unit (requester 0) and the vector accelerator memory interface
// (requester 1). Requests are arbitrated round-robin, each accepted request
// is tagged with a transaction ID (TID) from a small pool, and out-of-order
// responses are steered back to the requester that owns the TID. New grants
// are inhibited while flush_i is high so the cache can drain.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i[1:0]       per-requester request valid (bit0 CVA6, bit1 acc)
//   req_ready_o[1:0]       per-requester request accepted (transfer cycle)
//   req_addr_i/we/wdata/be per-requester request fields, packed {req1, req0}
//   cache_req_*_o          request forwarded to the D-cache, with its TID
//   cache_req_ready_i      D-cache accepts the forwarded request
//   cache_rsp_valid_i      D-cache response (no backpressure)
//   cache_rsp_tid_i        TID the response belongs to
//   cache_rsp_rdata_i      response data (ignored by requesters for writes)
//   rsp_valid_o[1:0]       per-requester response valid
//   rsp_rdata_o            response data shared by both requesters
//   flush_i                inhibit new grants
//   idle_o                 no TID in flight and nothing offered to the cache
//   err_o                  sticky: response seen for an unallocated TID
// ----------------------------------------------------------------------------
module acc_dcache_port_arbiter #(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned MemTidWidth = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [1:0]                   req_valid_i,
   output logic [1:0]                   req_ready_o,
   input  logic [2*AddrWidth-1:0]       req_addr_i,
   input  logic [1:0]                   req_we_i,
   input  logic [2*DataWidth-1:0]       req_wdata_i,
   input  logic [2*(DataWidth/8)-1:0]   req_be_i,
   output logic                         cache_req_valid_o,
   input  logic                         cache_req_ready_i,
   output logic [AddrWidth-1:0]         cache_req_addr_o,
   output logic                         cache_req_we_o,
   output logic [DataWidth-1:0]         cache_req_wdata_o,
   output logic [DataWidth/8-1:0]       cache_req_be_o,
   output logic [MemTidWidth-1:0]       cache_req_tid_o,
   input  logic                         cache_rsp_valid_i,
   input  logic [MemTidWidth-1:0]       cache_rsp_tid_i,
   input  logic [DataWidth-1:0]         cache_rsp_rdata_i,
   output logic [1:0]                   rsp_valid_o,
   output logic [DataWidth-1:0]         rsp_rdata_o,
   input  logic                         flush_i,
   output logic                         idle_o,
   output logic                         err_o
);

   localparam int NrTids  = 2 ** MemTidWidth;
   localparam int BeWidth = DataWidth / 8;

   // Lowest-index free TID, returned as {found, index}. Searches the
   // registered busy vector only, so a TID released this cycle is never
   // reallocated in the same cycle.
   function automatic logic [MemTidWidth:0] find_free(input logic [NrTids-1:0] busy);
      logic                   found;
      logic [MemTidWidth-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NrTids; i++) begin
         if (!found && !busy[i]) begin
            found = 1'b1;
            idx   = MemTidWidth'(i);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [NrTids-1:0]      tid_busy_q, tid_busy_d;
   logic [NrTids-1:0]      owner_q,    owner_d;     // requester index per TID
   logic                   rr_ptr_q,   rr_ptr_d;
   logic                   lock_q,     lock_d;
   logic                   lock_sel_q, lock_sel_d;
   logic [MemTidWidth-1:0] lock_tid_q, lock_tid_d;
   logic                   err_q,      err_d;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [MemTidWidth:0]   free_s;
   logic                   free_found_s;
   logic [MemTidWidth-1:0] free_tid_s;
   logic                   can_grant_s;
   logic                   sel_s;
   logic [MemTidWidth-1:0] tid_s;
   logic                   valid_s;
   logic                   transfer_s;
   logic                   rsp_hit_s;
   logic                   rsp_miss_s;

   assign free_s       = find_free(tid_busy_q);
   assign free_found_s = free_s[MemTidWidth];
   assign free_tid_s   = free_s[MemTidWidth-1:0];
   assign can_grant_s  = !flush_i && free_found_s;

   // Requester selection and TID choice. Once a request has been offered
   // without being accepted, the selection and TID are frozen (lock) so the
   // cache sees a stable request even if flush_i rises or the other
   // requester becomes valid.
   always_comb begin
      sel_s   = 1'b0;
      tid_s   = '0;
      valid_s = 1'b0;
      if (lock_q) begin
         sel_s   = lock_sel_q;
         tid_s   = lock_tid_q;
         valid_s = 1'b1;
      end else begin
         case (req_valid_i)
            2'b11:   sel_s = rr_ptr_q;
            2'b10:   sel_s = 1'b1;
            2'b01:   sel_s = 1'b0;
            default: sel_s = 1'b0;
         endcase
         tid_s   = free_tid_s;
         valid_s = can_grant_s && (req_valid_i != 2'b00);
      end
   end

   assign transfer_s = valid_s && cache_req_ready_i;

   // Forwarded request fields; held at zero whenever nothing is offered.
   always_comb begin
      cache_req_valid_o = valid_s;
      cache_req_tid_o   = '0;
      cache_req_addr_o  = '0;
      cache_req_we_o    = 1'b0;
      cache_req_wdata_o = '0;
      cache_req_be_o    = '0;
      if (valid_s) begin
         cache_req_tid_o = tid_s;
         if (sel_s) begin
            cache_req_addr_o  = req_addr_i[AddrWidth +: AddrWidth];
            cache_req_we_o    = req_we_i[1];
            cache_req_wdata_o = req_wdata_i[DataWidth +: DataWidth];
            cache_req_be_o    = req_be_i[BeWidth +: BeWidth];
         end else begin
            cache_req_addr_o  = req_addr_i[0 +: AddrWidth];
            cache_req_we_o    = req_we_i[0];
            cache_req_wdata_o = req_wdata_i[0 +: DataWidth];
            cache_req_be_o    = req_be_i[0 +: BeWidth];
         end
      end else begin
         cache_req_tid_o = '0;
      end
   end

   // Accept goes back only to the selected requester, on the transfer cycle.
   always_comb begin
      req_ready_o = 2'b00;
      if (transfer_s) begin
         req_ready_o[sel_s] = 1'b1;
      end else begin
         req_ready_o = 2'b00;
      end
   end

   assign rsp_hit_s  = cache_rsp_valid_i &&  tid_busy_q[cache_rsp_tid_i];
   assign rsp_miss_s = cache_rsp_valid_i && !tid_busy_q[cache_rsp_tid_i];

   // Response routing by TID owner; a response to a free TID is dropped.
   always_comb begin
      rsp_valid_o = 2'b00;
      rsp_rdata_o = '0;
      if (rsp_hit_s) begin
         rsp_valid_o[owner_q[cache_rsp_tid_i]] = 1'b1;
         rsp_rdata_o                           = cache_rsp_rdata_i;
      end else begin
         rsp_rdata_o = '0;
      end
   end

   assign idle_o = (tid_busy_q == '0) && !valid_s;
   assign err_o  = err_q;

   // Next-state: TID release, TID allocation, round-robin pointer and lock.
   // Release and allocation can hit in the same cycle; they always target
   // different TIDs because allocation only picks registered-free TIDs.
   always_comb begin
      tid_busy_d = tid_busy_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      lock_tid_d = lock_tid_q;
      err_d      = err_q;

      if (rsp_hit_s) begin
         tid_busy_d[cache_rsp_tid_i] = 1'b0;
      end else begin
         tid_busy_d = tid_busy_d;
      end

      if (transfer_s) begin
         tid_busy_d[tid_s] = 1'b1;
         owner_d[tid_s]    = sel_s;
         rr_ptr_d          = ~sel_s;
         lock_d            = 1'b0;
      end else if (valid_s) begin
         lock_d     = 1'b1;
         lock_sel_d = sel_s;
         lock_tid_d = tid_s;
      end else begin
         lock_d = lock_q;
      end

      if (rsp_miss_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tid_busy_q <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= 1'b0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         lock_tid_q <= '0;
         err_q      <= 1'b0;
      end else begin
         tid_busy_q <= tid_busy_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         lock_tid_q <= lock_tid_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_acc_dcache_port_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for acc_dcache_port_arbiter. Directed stimulus pushes expected
// grants and responses into queues; a monitor on the falling edge pops and
// compares whenever the DUT shows a transfer or a response.
// ----------------------------------------------------------------------------
module tb_acc_dcache_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TW = 2;

   localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
   localparam logic [63:0] A1 = 64'h0000_0000_9000_0040;

   logic              clk;
   logic              rst_ni;
   logic [1:0]        req_valid_i;
   logic [1:0]        req_ready_o;
   logic [2*AW-1:0]   req_addr_i;
   logic [1:0]        req_we_i;
   logic [2*DW-1:0]   req_wdata_i;
   logic [2*DW/8-1:0] req_be_i;
   logic              cache_req_valid_o;
   logic              cache_req_ready_i;
   logic [AW-1:0]     cache_req_addr_o;
   logic              cache_req_we_o;
   logic [DW-1:0]     cache_req_wdata_o;
   logic [DW/8-1:0]   cache_req_be_o;
   logic [TW-1:0]     cache_req_tid_o;
   logic              cache_rsp_valid_i;
   logic [TW-1:0]     cache_rsp_tid_i;
   logic [DW-1:0]     cache_rsp_rdata_i;
   logic [1:0]        rsp_valid_o;
   logic [DW-1:0]     rsp_rdata_o;
   logic              flush_i;
   logic              idle_o;
   logic              err_o;

   acc_dcache_port_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .MemTidWidth(TW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i),
      .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
      .cache_req_addr_o(cache_req_addr_o), .cache_req_we_o(cache_req_we_o),
      .cache_req_wdata_o(cache_req_wdata_o), .cache_req_be_o(cache_req_be_o),
      .cache_req_tid_o(cache_req_tid_o),
      .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_tid_i(cache_rsp_tid_i),
      .cache_rsp_rdata_i(cache_rsp_rdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .flush_i(flush_i), .idle_o(idle_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    rdy;
      logic [TW-1:0] tid;
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
   } grant_t;

   typedef struct {
      logic [1:0]    vld;
      logic [DW-1:0] rdata;
   } rsp_t;

   grant_t gq[$];
   rsp_t   rq[$];
   int     n_vec = 0;
   int     n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected grant for requester r with tid; fields come from what the bench drives.
   task automatic push_grant(input int r, input int tid);
      grant_t g;
      g.rdy   = (r == 1) ? 2'b10 : 2'b01;
      g.tid   = TW'(tid);
      g.addr  = (r == 1) ? req_addr_i[AW +: AW] : req_addr_i[0 +: AW];
      g.we    = (r == 1) ? req_we_i[1] : req_we_i[0];
      g.wdata = (r == 1) ? req_wdata_i[DW +: DW] : req_wdata_i[0 +: DW];
      gq.push_back(g);
   endtask

   task automatic push_rsp(input logic [1:0] vld, input logic [DW-1:0] data);
      rsp_t r;
      r.vld   = vld;
      r.rdata = data;
      rq.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni            = 1'b0;
      req_valid_i       = 2'b00;
      req_we_i          = 2'b00;
      cache_req_ready_i = 1'b0;
      cache_rsp_valid_i = 1'b0;
      cache_rsp_tid_i   = 2'd0;
      cache_rsp_rdata_i = 64'd0;
      flush_i           = 1'b0;
      #2;
      chk("rst_idle", 64'(idle_o), 64'd1);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_cvalid", 64'(cache_req_valid_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_rspv", 64'(rsp_valid_o), 64'd0);
      chk("rst_addr", cache_req_addr_o, 64'd0);
      chk("rst_rdata", rsp_rdata_o, 64'd0);
      step();
      step();
      rst_ni = 1'b1;
   endtask

   // Monitor: every transfer and every response must match the next expectation.
   always @(negedge clk) begin
      if (cache_req_valid_o && cache_req_ready_i) begin
         n_vec++;
         if (gq.size() == 0) begin
            n_err++;
            $display("FAIL grant_unexpected: got ready %b tid %0d, expected no grant", req_ready_o, cache_req_tid_o);
         end else begin
            grant_t g;
            g = gq.pop_front();
            if (req_ready_o !== g.rdy || cache_req_tid_o !== g.tid || cache_req_addr_o !== g.addr ||
                cache_req_we_o !== g.we || cache_req_wdata_o !== g.wdata) begin
               n_err++;
               $display("FAIL grant: got ready %b tid %0d addr %h we %b wdata %h, expected ready %b tid %0d addr %h we %b wdata %h",
                        req_ready_o, cache_req_tid_o, cache_req_addr_o, cache_req_we_o, cache_req_wdata_o,
                        g.rdy, g.tid, g.addr, g.we, g.wdata);
            end
         end
      end
      if (rsp_valid_o != 2'b00) begin
         n_vec++;
         if (rq.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid %b rdata %h, expected none", rsp_valid_o, rsp_rdata_o);
         end else begin
            rsp_t r;
            r = rq.pop_front();
            if (rsp_valid_o !== r.vld || rsp_rdata_o !== r.rdata) begin
               n_err++;
               $display("FAIL rsp: got valid %b rdata %h, expected valid %b rdata %h",
                        rsp_valid_o, rsp_rdata_o, r.vld, r.rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      req_addr_i  = {A1, A0};
      req_wdata_i = {64'hB1B1_B1B1_0000_1111, 64'hA0A0_A0A0_0000_0000};
      req_be_i    = 16'hFFFF;

      // Single read from requester 0.
      do_reset();
      req_valid_i       = 2'b01;
      cache_req_ready_i = 1'b1;
      push_grant(0, 0);
      #2;
      chk("t1_tid", 64'(cache_req_tid_o), 64'd0);
      chk("t1_ready", 64'(req_ready_o), 64'd1);
      step();
      req_valid_i       = 2'b00;
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = 2'd0;
      cache_rsp_rdata_i = 64'h0000_0000_DEAD_BEEF;
      push_rsp(2'b01, 64'h0000_0000_DEAD_BEEF);
      step();
      cache_rsp_valid_i = 1'b0;
      #2;
      chk("t1_idle", 64'(idle_o), 64'd1);

      // Contention: alternate grants until the pool is full.
      do_reset();
      req_valid_i       = 2'b11;
      cache_req_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_grant(k % 2, k);
         step();
      end
      #2;
      chk("t2_full_valid", 64'(cache_req_valid_o), 64'd0);
      chk("t2_full_ready", 64'(req_ready_o), 64'd0);
      step();
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = 2'd2;
      cache_rsp_rdata_i = 64'h1111_2222_3333_4444;
      push_rsp(2'b01, 64'h1111_2222_3333_4444);
      #2;
      chk("t2_release_nogrant", 64'(cache_req_valid_o), 64'd0);
      step();
      cache_rsp_valid_i = 1'b0;
      push_grant(0, 2);
      step();
      req_valid_i = 2'b00;

      // Out-of-order return.
      do_reset();
      req_valid_i       = 2'b11;
      cache_req_ready_i = 1'b1;
      push_grant(0, 0);
      step();
      push_grant(1, 1);
      step();
      req_valid_i       = 2'b00;
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = 2'd1;
      cache_rsp_rdata_i = 64'h0000_0000_0000_2222;
      push_rsp(2'b10, 64'h0000_0000_0000_2222);
      step();
      cache_rsp_tid_i   = 2'd0;
      cache_rsp_rdata_i = 64'h0000_0000_0000_3333;
      push_rsp(2'b01, 64'h0000_0000_0000_3333);
      step();
      cache_rsp_valid_i = 1'b0;
      req_valid_i       = 2'b10;
      push_grant(1, 0);
      step();
      req_valid_i = 2'b00;

      // Backpressure and lock; flush rising while locked must not drop valid.
      do_reset();
      req_valid_i       = 2'b10;
      cache_req_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) req_valid_i = 2'b11;
         if (c == 2) flush_i = 1'b1;
         #2;
         chk("t4_lock_valid", 64'(cache_req_valid_o), 64'd1);
         chk("t4_lock_addr", cache_req_addr_o, A1);
         chk("t4_lock_tid", 64'(cache_req_tid_o), 64'd0);
         chk("t4_lock_ready", 64'(req_ready_o), 64'd0);
         step();
      end
      cache_req_ready_i = 1'b1;
      push_grant(1, 0);
      step();
      flush_i     = 1'b0;
      req_valid_i = 2'b01;
      push_grant(0, 1);
      step();
      req_valid_i = 2'b00;

      // Flush blocks grants; response to a free TID sets sticky error.
      do_reset();
      flush_i           = 1'b1;
      req_valid_i       = 2'b01;
      cache_req_ready_i = 1'b1;
      #2;
      chk("t5_flush_valid", 64'(cache_req_valid_o), 64'd0);
      chk("t5_flush_idle", 64'(idle_o), 64'd1);
      chk("t5_flush_ready", 64'(req_ready_o), 64'd0);
      step();
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = 2'd2;
      cache_rsp_rdata_i = 64'h0000_0000_0000_4444;
      #2;
      chk("t5_bad_rspv", 64'(rsp_valid_o), 64'd0);
      chk("t5_err_before", 64'(err_o), 64'd0);
      step();
      cache_rsp_valid_i = 1'b0;
      #2;
      chk("t5_err_set", 64'(err_o), 64'd1);
      step();
      chk("t5_err_sticky", 64'(err_o), 64'd1);
      flush_i = 1'b0;
      push_grant(0, 0);
      step();
      req_valid_i = 2'b00;
      #2;
      chk("t5_err_sticky2", 64'(err_o), 64'd1);

      // Full pool with same-cycle release: grant only on the following cycle.
      do_reset();
      req_we_i          = 2'b01;
      req_wdata_i[0 +: DW] = 64'h5A5A_5A5A_1234_5678;
      req_valid_i       = 2'b01;
      cache_req_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_grant(0, k);
         step();
      end
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = 2'd3;
      cache_rsp_rdata_i = 64'h0000_0000_0000_5555;
      push_rsp(2'b01, 64'h0000_0000_0000_5555);
      #2;
      chk("t6_same_cycle_nogrant", 64'(cache_req_valid_o), 64'd0);
      step();
      cache_rsp_valid_i = 1'b0;
      push_grant(0, 3);
      #2;
      chk("t6_next_tid", 64'(cache_req_tid_o), 64'd3);
      step();
      req_valid_i = 2'b00;
      step();

      chk("grant_queue_drained", 64'(gq.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
